// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-cache backing memory.
// Block addressing works on word indices; the byte offset and upper address bits are dropped.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        READ_WAIT,
        RESP
    } state_t;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;

    // Word index of the first word of the 4-word block holding byte address addr.
    function automatic logic [31:0] blk_base(input logic [31:0] addr, input int aw);
        logic [31:0] idx;
        idx = (addr >> 2) & ((32'd1 << aw) - 32'd1);
        return idx & ~32'd3;
    endfunction

endpackage

// File: rtl/dmem_write_fifo.sv
// Posted-store FIFO of {word index, data} entries between the cache and the array.
// Full/empty come from the registered count, so a refused push stays refused for the whole cycle.
module dmem_write_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 42
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = entries[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= din;
    end

endmodule

// File: rtl/dcache_backing_mem.sv
// Main data memory behind the write-through data cache: fixed-latency 4-word line fills
// and a posted store buffer that is always drained before a fill reads the array.
module dcache_backing_mem
    import dmem_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter int    READ_LAT  = 3,
    parameter int    WB_DEPTH  = 4,
    parameter string INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               ird_req,
    input  logic [31:0]        ird_addr,
    output logic [BLOCK_W-1:0] ord_data,
    output logic               ord_valid,
    input  logic               iwr_req,
    input  logic [31:0]        iwr_addr,
    input  logic [WORD_W-1:0]  iwr_data,
    output logic               owr_ready,
    output logic               obusy
);

    localparam int CW = $clog2(WB_DEPTH) + 1;
    localparam int EW = ADDR_W + WORD_W;
    localparam int LW = $clog2(READ_LAT + 1);
    localparam logic [LW-1:0] LAT_TOP = LW'(READ_LAT);

    state_t             state;
    state_t             state_next;
    logic [LW-1:0]      wait_cnt;
    logic [LW-1:0]      wait_cnt_next;
    logic [ADDR_W-1:0]  blk_idx;
    logic [ADDR_W-1:0]  blk_idx_next;
    logic [31:0]        base_full;

    logic               wb_push;
    logic               wb_pop;
    logic               wb_full;
    logic               wb_empty;
    logic [CW-1:0]      wb_count;
    logic [CW-1:0]      wb_count_next;
    logic [EW-1:0]      wb_din;
    logic [EW-1:0]      wb_dout;

    logic [WORD_W-1:0]  mem [2**ADDR_W];
    logic               unused_bits;

    assign owr_ready     = (state == IDLE) && !wb_full;
    assign wb_push       = iwr_req && owr_ready;
    assign wb_pop        = ((state == IDLE) || (state == DRAIN)) && !wb_empty;
    assign wb_din        = {iwr_addr[ADDR_W+1:2], iwr_data};
    // Occupancy after this cycle's push/pop decides whether a fill must drain first.
    assign wb_count_next = wb_count + CW'(wb_push) - CW'(wb_pop);
    assign obusy         = (state != IDLE) || !wb_empty;
    assign base_full     = blk_base(ird_addr, ADDR_W);
    assign unused_bits   = &{1'b0, iwr_addr[31:ADDR_W+2], iwr_addr[1:0], base_full[31:ADDR_W]};

    dmem_write_fifo #(
        .DEPTH (WB_DEPTH),
        .W     (EW)
    ) u_wbuf (
        .clk   (clk),
        .rstn  (rstn),
        .push  (wb_push),
        .pop   (wb_pop),
        .din   (wb_din),
        .dout  (wb_dout),
        .full  (wb_full),
        .empty (wb_empty),
        .count (wb_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            blk_idx  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            blk_idx  <= blk_idx_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        blk_idx_next  = blk_idx;
        case (state)
            IDLE: begin
                if (ird_req) begin
                    blk_idx_next = base_full[ADDR_W-1:0];
                    state_next   = (wb_count_next != '0) ? DRAIN : READ_WAIT;
                end
            end
            DRAIN: begin
                if (wb_count_next == '0) state_next = READ_WAIT;
            end
            READ_WAIT: begin
                wait_cnt_next = wait_cnt + LW'(1);
                if (wait_cnt_next == LAT_TOP) state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_pop) mem[wb_dout[EW-1:WORD_W]] <= wb_dout[WORD_W-1:0];
    end

    // Block words are captured on the RESP edge and held until the next fill.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ord_data  <= '0;
            ord_valid <= 1'b0;
        end else begin
            ord_valid <= (state == RESP);
            if (state == RESP) begin
                for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
                    ord_data[k*WORD_W +: WORD_W] <= mem[blk_idx + ADDR_W'(k)];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_backing_mem.sv
// Directed bench for dcache_backing_mem: reset, fill latency/data, posted stores,
// store-before-fill ordering, fill after a store burst, and address wrap.
module tb_dcache_backing_mem;

    logic         clk;
    logic         rstn;
    logic         ird_req;
    logic [31:0]  ird_addr;
    logic [127:0] ord_data;
    logic         ord_valid;
    logic         iwr_req;
    logic [31:0]  iwr_addr;
    logic [31:0]  iwr_data;
    logic         owr_ready;
    logic         obusy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [31:0]  addr;
        logic [127:0] data;
        int           lat;
    } fill_vec_t;

    fill_vec_t vecs [6];

    dcache_backing_mem #(
        .ADDR_W    (10),
        .READ_LAT  (3),
        .WB_DEPTH  (4),
        .INIT_FILE ("")
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ird_req   (ird_req),
        .ird_addr  (ird_addr),
        .ord_data  (ord_data),
        .ord_valid (ord_valid),
        .iwr_req   (iwr_req),
        .iwr_addr  (iwr_addr),
        .iwr_data  (iwr_data),
        .owr_ready (owr_ready),
        .obusy     (obusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        chk("owr_ready before store", owr_ready, 1);
        iwr_req  = 1'b1;
        iwr_addr = addr;
        iwr_data = data;
        @(posedge clk);
        #1 iwr_req = 1'b0;
    endtask

    task automatic issue_fill(input logic [31:0] addr);
        @(negedge clk);
        ird_req  = 1'b1;
        ird_addr = addr;
        @(posedge clk);
        #1 ird_req = 1'b0;
    endtask

    // Called just after the request edge; counts edges until ord_valid is seen.
    task automatic wait_resp(input string name, input logic [127:0] exp_data,
                             input int exp_lat, input bit chk_ready);
        int lat;
        bit seen;
        bit ready_bad;
        lat = 0;
        seen = 0;
        ready_bad = 0;
        while (!seen && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ord_valid) seen = 1;
            else if (owr_ready) ready_bad = 1;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " data"}, ord_data, exp_data);
        if (chk_ready) chk({name, " owr_ready low while busy"}, ready_bad, 0);
        @(negedge clk);
        chk({name, " valid one cycle"}, ord_valid, 0);
        chk({name, " data held"}, ord_data, exp_data);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (obusy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, " idle"}, obusy, 0);
    endtask

    initial begin
        bit seen;
        rstn     = 1'b0;
        ird_req  = 1'b0;
        ird_addr = '0;
        iwr_req  = 1'b0;
        iwr_addr = '0;
        iwr_data = '0;

        vecs[0] = '{"fill 0x40",  32'h40,   {32'h1013, 32'h1012, 32'h1011, 32'h1010}, 4};
        vecs[1] = '{"fill 0x4C",  32'h4C,   {32'h1013, 32'h1012, 32'h1011, 32'h1010}, 4};
        vecs[2] = '{"fill 0x0",   32'h0,    {32'h1003, 32'h1002, 32'h1001, 32'h1000}, 4};
        vecs[3] = '{"fill top",   32'hFF0,  {32'h13FF, 32'h13FE, 32'h13FD, 32'h13FC}, 4};
        vecs[4] = '{"wrap 0x1000", 32'h1000, {32'h1003, 32'h1002, 32'h1001, 32'h1000}, 4};
        vecs[5] = '{"wrap 0x104F", 32'h104F, {32'h1013, 32'h1012, 32'h1011, 32'h1010}, 4};

        repeat (3) @(negedge clk);
        chk("reset ord_valid", ord_valid, 0);
        chk("reset ord_data", ord_data, 0);
        chk("reset owr_ready", owr_ready, 1);
        chk("reset obusy", obusy, 0);
        rstn = 1'b1;

        // Preload blocks 0, 0x40 and the top block with 0x1000 + word index.
        for (int i = 0; i < 4; i++) store(32'(i * 4), 32'h1000 + 32'(i));
        for (int i = 16; i < 20; i++) store(32'(i * 4), 32'h1000 + 32'(i));
        for (int i = 1020; i < 1024; i++) store(32'(i * 4), 32'h1000 + 32'(i));
        wait_idle("preload");

        // Reset in READ_WAIT aborts the fill.
        issue_fill(32'h40);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid reset ord_valid", ord_valid, 0);
        chk("mid reset owr_ready", owr_ready, 1);
        chk("mid reset obusy", obusy, 0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ord_valid) seen = 1;
        end
        chk("aborted fill no valid", seen, 0);

        // A buffered store not yet retired is discarded by reset.
        @(negedge clk);
        iwr_req  = 1'b1;
        iwr_addr = 32'h4;
        iwr_data = 32'h0BAD0BAD;
        ird_req  = 1'b1;
        ird_addr = 32'h0;
        @(posedge clk);
        #1;
        iwr_req = 1'b0;
        ird_req = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        issue_fill(32'h0);
        wait_resp("discarded store", {32'h1003, 32'h1002, 32'h1001, 32'h1000}, 4, 1'b0);

        for (int v = 0; v < 6; v++) begin
            issue_fill(vecs[v].addr);
            wait_resp(vecs[v].name, vecs[v].data, vecs[v].lat, 1'b1);
        end

        // Back-to-back posted stores, including a repeat to the same word.
        store(32'h100, 32'hA1);
        store(32'h104, 32'hB2);
        store(32'h108, 32'hC3);
        store(32'h10C, 32'hD4);
        store(32'h100, 32'hE5);
        issue_fill(32'h100);
        wait_resp("store order", {32'hD4, 32'hC3, 32'hB2, 32'hE5}, 4, 1'b1);

        // Store and fill in the same cycle: one DRAIN cycle, fill sees the store.
        @(negedge clk);
        iwr_req  = 1'b1;
        iwr_addr = 32'h44;
        iwr_data = 32'hDEADBEEF;
        ird_req  = 1'b1;
        ird_addr = 32'h40;
        @(posedge clk);
        #1;
        iwr_req = 1'b0;
        ird_req = 1'b0;
        wait_resp("raw", {32'h1013, 32'h1012, 32'hDEADBEEF, 32'h1010}, 5, 1'b1);

        // Store burst to 0x80..0x8C immediately followed by a fill of that block.
        for (int i = 0; i < 4; i++) store(32'h80 + 32'(i * 4), 32'h5500 + 32'(i));
        issue_fill(32'h80);
        wait_resp("burst fill", {32'h5503, 32'h5502, 32'h5501, 32'h5500}, 4, 1'b1);

        wait_idle("end");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
